// File: rtl/ir_prefetch_q_if.sv
// Fetch/decode bundle for ir_prefetch_q: push handshake, IR load request, flush and status.
// master = fetch/decode control side, slave = the prefetch queue itself.
interface ir_prefetch_q_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 2
);
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             en_ir;
  logic [WIDTH-1:0] ir_out;
  logic             ir_valid;
  logic [AW:0]      count;

  modport master (
    output flush, in_valid, in_data, en_ir,
    input  in_ready, ir_out, ir_valid, count
  );

  modport slave (
    input  flush, in_valid, in_data, en_ir,
    output in_ready, ir_out, ir_valid, count
  );
endinterface

// File: rtl/ir_prefetch_q.sv
// Instruction register fed by a DEPTH-entry prefetch FIFO; flush invalidates queue and IR.
// Optional macro IR_BYPASS_EN: an empty-queue push with en_ir loads in_data straight into the IR.
module ir_prefetch_q #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input logic clk,
  input logic clr,
  ir_prefetch_q_if.slave bus
);

  localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_q;
  logic [AW:0]      count_d;
  logic [WIDTH-1:0] ir_q;
  logic             ir_valid_q;
  logic             ready;
  logic             push;
  logic             pop;
  logic             bypass;

  // Readiness looks only at registered occupancy, so a full queue refuses a push even while popping.
  assign ready        = (count_q != FULL);
  assign bus.in_ready = ready;
  assign bus.ir_out   = ir_q;
  assign bus.ir_valid = ir_valid_q;
  assign bus.count    = count_q;

  always_comb begin
    bypass = 1'b0;
`ifdef IR_BYPASS_EN
    bypass = bus.in_valid && bus.en_ir && (count_q == '0) && !bus.flush;
`endif
    push    = bus.in_valid && ready && !bus.flush && !bypass;
    pop     = bus.en_ir && (count_q != '0) && !bus.flush;
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (pop && !push) begin
      count_d = count_q - CNT_ONE;
    end
  end

  // Storage is deliberately left uncleared; the pointers alone define what is live.
  always_ff @(posedge clk) begin
    if (push && clr) begin
      mem[wr_ptr] <= bus.in_data;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr     <= rd_ptr + PTR_ONE;
        ir_q       <= mem[rd_ptr];
        ir_valid_q <= 1'b1;
      end else if (bypass) begin
        ir_q       <= bus.in_data;
        ir_valid_q <= 1'b1;
      end else if (bus.en_ir) begin
        ir_valid_q <= 1'b0;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_ir_prefetch_q.sv
// Self-checking bench for ir_prefetch_q: directed scenarios plus random traffic against a queue model.
module tb_ir_prefetch_q;
  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic clk;
  logic clr;
  ir_prefetch_q_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  ir_prefetch_q #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  logic [WIDTH-1:0] q [$];
  logic [WIDTH-1:0] m_ir;
  logic             m_irv;
  int checks;
  int failures;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic model_reset();
    q.delete();
    m_ir  = '0;
    m_irv = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model at the edge, sample 1 time unit later.
  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic e, input logic f);
    bit ready;
    bus.in_valid = v;
    bus.in_data  = d;
    bus.en_ir    = e;
    bus.flush    = f;
    ready = (q.size() != DEPTH);
    @(posedge clk);
    if (f) begin
      q.delete();
      m_irv = 1'b0;
    end else
`ifdef IR_BYPASS_EN
    if (e && v && q.size() == 0) begin
      m_ir  = d;
      m_irv = 1'b1;
    end else
`endif
    begin
      if (e) begin
        if (q.size() != 0) begin
          m_ir  = q.pop_front();
          m_irv = 1'b1;
        end else begin
          m_irv = 1'b0;
        end
      end
      if (v && ready) q.push_back(d);
    end
    #1;
    bus.in_valid = 1'b0;
    bus.en_ir    = 1'b0;
    bus.flush    = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.en_ir = 1'b0; bus.flush = 1'b0;
    model_reset();
    #23;
    clr = 1'b1;
    @(negedge clk);
    checks += 4;
    if (bus.ir_out !== 16'h0000) begin failures++; $display("[TB] FAIL reset_ir_out got %h required 0000", bus.ir_out); end
    if (bus.ir_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_ir_valid got %b required 0", bus.ir_valid); end
    if (bus.count !== 3'd0) begin failures++; $display("[TB] FAIL reset_count got %0d required 0", bus.count); end
    if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready got %b required 1", bus.in_ready); end
  endtask

  task automatic test_fill_drain();
    logic [WIDTH-1:0] words [4];
    words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333; words[3] = 16'h4444;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, words[i], 1'b0, 1'b0);
      checks++;
      if (bus.count !== 3'(i + 1)) begin failures++; $display("[TB] FAIL fill_count got %0d required %0d", bus.count, i + 1); end
    end
    checks++;
    if (bus.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL full_in_ready got %b required 0", bus.in_ready); end
    step(1'b1, 16'h5555, 1'b0, 1'b0);
    checks++;
    if (bus.count !== 3'd4) begin failures++; $display("[TB] FAIL refused_push_count got %0d required 4", bus.count); end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      checks += 2;
      if (bus.ir_out !== words[i]) begin failures++; $display("[TB] FAIL drain_ir_out got %h required %h", bus.ir_out, words[i]); end
      if (bus.ir_valid !== 1'b1) begin failures++; $display("[TB] FAIL drain_ir_valid got %b required 1", bus.ir_valid); end
    end
    checks++;
    if (bus.count !== 3'd0) begin failures++; $display("[TB] FAIL drain_count got %0d required 0", bus.count); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 16'(16'hA000 + i), 1'b0, 1'b0);
      checks++;
      if (bus.count > 3'd1) begin failures++; $display("[TB] FAIL wrap_count got %0d required <=1", bus.count); end
      step(1'b0, '0, 1'b1, 1'b0);
      checks += 2;
      if (bus.ir_out !== 16'(16'hA000 + i)) begin failures++; $display("[TB] FAIL wrap_ir_out got %h required %h", bus.ir_out, 16'(16'hA000 + i)); end
      if (bus.count !== 3'd0) begin failures++; $display("[TB] FAIL wrap_count_after_pop got %0d required 0", bus.count); end
    end
  endtask

  task automatic test_full_pop();
    logic [WIDTH-1:0] head;
    for (int i = 0; i < DEPTH; i++) step(1'b1, 16'($urandom), 1'b0, 1'b0);
    head = q[0];
    step(1'b1, 16'h9999, 1'b1, 1'b0);
    checks += 2;
    if (bus.ir_out !== head) begin failures++; $display("[TB] FAIL full_pop_ir_out got %h required %h", bus.ir_out, head); end
    if (bus.count !== 3'd3) begin failures++; $display("[TB] FAIL full_pop_count got %0d required 3", bus.count); end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      checks++;
      if (bus.ir_out !== m_ir) begin failures++; $display("[TB] FAIL full_pop_drain got %h required %h", bus.ir_out, m_ir); end
    end
    checks++;
    if (bus.count !== 3'd0) begin failures++; $display("[TB] FAIL full_pop_final_count got %0d required 0 (0x9999 must not be stored)", bus.count); end
  endtask

  task automatic test_flush();
    step(1'b1, 16'h1234, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 16'($urandom), 1'b0, 1'b0);
    checks += 2;
    if (bus.ir_out !== 16'h1234) begin failures++; $display("[TB] FAIL preflush_ir_out got %h required 1234", bus.ir_out); end
    if (bus.count !== 3'd3) begin failures++; $display("[TB] FAIL preflush_count got %0d required 3", bus.count); end
    step(1'b1, 16'h7777, 1'b1, 1'b1);
    checks += 4;
    if (bus.count !== 3'd0) begin failures++; $display("[TB] FAIL flush_count got %0d required 0", bus.count); end
    if (bus.ir_valid !== 1'b0) begin failures++; $display("[TB] FAIL flush_ir_valid got %b required 0", bus.ir_valid); end
    if (bus.ir_out !== 16'h1234) begin failures++; $display("[TB] FAIL flush_ir_out got %h required 1234", bus.ir_out); end
    if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL flush_in_ready got %b required 1", bus.in_ready); end
    step(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (bus.ir_valid !== 1'b0) begin failures++; $display("[TB] FAIL post_flush_pop_valid got %b required 0", bus.ir_valid); end
  endtask

  task automatic test_empty_push_pop();
    step(1'b1, 16'hBEEF, 1'b1, 1'b0);
    checks += 2;
`ifdef IR_BYPASS_EN
    if (bus.ir_out !== 16'hBEEF || bus.ir_valid !== 1'b1) begin failures++; $display("[TB] FAIL bypass_ir got %h/%b required BEEF/1", bus.ir_out, bus.ir_valid); end
    if (bus.count !== 3'd0) begin failures++; $display("[TB] FAIL bypass_count got %0d required 0", bus.count); end
`else
    if (bus.ir_valid !== 1'b0) begin failures++; $display("[TB] FAIL empty_pp_valid got %b required 0", bus.ir_valid); end
    if (bus.count !== 3'd1) begin failures++; $display("[TB] FAIL empty_pp_count got %0d required 1", bus.count); end
    step(1'b0, '0, 1'b1, 1'b0);
    checks += 2;
    if (bus.ir_out !== 16'hBEEF) begin failures++; $display("[TB] FAIL empty_pp_next_ir got %h required BEEF", bus.ir_out); end
    if (bus.ir_valid !== 1'b1) begin failures++; $display("[TB] FAIL empty_pp_next_valid got %b required 1", bus.ir_valid); end
`endif
  endtask

  task automatic test_async_reset();
    step(1'b1, 16'h0F0F, 1'b0, 1'b0);
    step(1'b1, 16'hF0F0, 1'b1, 1'b0);
    bus.in_valid = 1'b1; bus.in_data = 16'hCAFE; bus.en_ir = 1'b1;
    #2;
    clr = 1'b0;
    model_reset();
    #1;
    checks += 4;
    if (bus.ir_out !== 16'h0000) begin failures++; $display("[TB] FAIL async_ir_out got %h required 0000", bus.ir_out); end
    if (bus.ir_valid !== 1'b0) begin failures++; $display("[TB] FAIL async_ir_valid got %b required 0", bus.ir_valid); end
    if (bus.count !== 3'd0) begin failures++; $display("[TB] FAIL async_count got %0d required 0", bus.count); end
    if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL async_in_ready got %b required 1", bus.in_ready); end
    @(posedge clk);
    #1;
    checks++;
    if (bus.count !== 3'd0) begin failures++; $display("[TB] FAIL async_hold_count got %0d required 0", bus.count); end
    bus.in_valid = 1'b0; bus.en_ir = 1'b0;
    #2;
    clr = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic v, e, f;
    for (int i = 0; i < 400; i++) begin
      v = 1'($urandom_range(0, 99) < 60);
      e = 1'($urandom_range(0, 99) < 45);
      f = 1'($urandom_range(0, 31) == 0);
      step(v, 16'($urandom), e, f);
      checks += 4;
      if (bus.ir_out !== m_ir) begin failures++; $display("[TB] FAIL rand_ir_out cycle %0d got %h required %h", i, bus.ir_out, m_ir); end
      if (bus.ir_valid !== m_irv) begin failures++; $display("[TB] FAIL rand_ir_valid cycle %0d got %b required %b", i, bus.ir_valid, m_irv); end
      if (bus.count !== 3'(q.size())) begin failures++; $display("[TB] FAIL rand_count cycle %0d got %0d required %0d", i, bus.count, q.size()); end
      if (bus.in_ready !== (q.size() != DEPTH)) begin failures++; $display("[TB] FAIL rand_in_ready cycle %0d got %b required %b", i, bus.in_ready, q.size() != DEPTH); end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_fill_drain();
    test_wrap();
    test_full_pop();
    test_flush();
    test_empty_push_pop();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
